fpu_fmul_pipe: RTL and testbench

//  Pipelined, width-parametrised FPU multiplier taking unpacked operands (signed unbiased exp, hidden-1 frac).

---
 rtl/fpu_fmul_pipe.sv | 150 +++++++++++++++
 tb/tb_fpu_fmul_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_fmul_pipe.sv
// fpu_fmul_pipe: three-stage unrounded FP multiplier on unpacked operands with valid/ready flow control,
// bubble collapse and flush; a downstream rounder/packer consumes the normalised product.
`timescale 1ns/1ps
module fpu_fmul_pipe #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int TAG_W  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                ven,
   input  logic                i_valid,
   output logic                i_ready,
   input  logic [TAG_W-1:0]    i_tag,
   input  logic                a_sign,
   input  logic                b_sign,
   input  logic [EXP_W:0]      a_exp,
   input  logic [EXP_W:0]      b_exp,
   input  logic [FRAC_W-1:0]   a_frac,
   input  logic [FRAC_W-1:0]   b_frac,
   input  logic                a_is_zero,
   input  logic                a_is_inf,
   input  logic                a_is_nan,
   input  logic                b_is_zero,
   input  logic                b_is_inf,
   input  logic                b_is_nan,
   output logic                o_valid,
   input  logic                o_ready,
   output logic [TAG_W-1:0]    o_tag,
   output logic                o_sign,
   output logic [EXP_W+1:0]    o_exp,
   output logic [2*FRAC_W:0]   o_frac,
   output logic                o_is_zero,
   output logic                o_is_inf,
   output logic                o_is_nan,
   output logic                invalid
);
   localparam int M  = FRAC_W + 1;
   localparam int L  = M / 2;
   localparam int H  = M - L;
   localparam int PW = 2 * M;
   localparam int EW = EXP_W + 2;

   logic             r1_valid, r1_sign, r1_nan, r1_inf, r1_zero, r1_inv;
   logic [TAG_W-1:0] r1_tag;
   logic [EW-1:0]    r1_exp;
   logic [M+L-1:0]   r1_pl;
   logic [M+H-1:0]   r1_ph;
   logic             r2_valid, r2_sign, r2_nan, r2_inf, r2_zero, r2_inv;
   logic [TAG_W-1:0] r2_tag;
   logic [EW-1:0]    r2_exp;
   logic [PW-2:0]    r2_frac;
   logic             w_s1_adv, w_s2_adv, w_s3_adv, w_acc, w_inv, w_nan;
   logic [M-1:0]     w_ma, w_mb;
   logic [PW-1:0]    w_p;

   // Each stage moves when it is empty or its successor moves, so empty slots absorb a stalled output.
   assign w_s3_adv = !o_valid || o_ready;
   assign w_s2_adv = !r2_valid || w_s3_adv;
   assign w_s1_adv = !r1_valid || w_s2_adv;
   assign i_ready  = w_s1_adv;
   assign w_acc    = i_valid && w_s1_adv && !flush;
   assign w_ma     = {1'b1, a_frac};
   assign w_mb     = {1'b1, b_frac};
   assign w_inv    = (a_is_nan && a_frac[FRAC_W-1]) || (b_is_nan && b_frac[FRAC_W-1]) ||
                     ((a_is_inf || b_is_inf) && (a_is_zero || b_is_zero));
   assign w_nan    = a_is_nan || b_is_nan || w_inv;
   assign w_p      = {{H{1'b0}}, r1_pl} + {r1_ph, {L{1'b0}}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_valid <= 1'b0;
         r1_tag   <= '0;
         r1_sign  <= 1'b0;
         r1_exp   <= '0;
         r1_nan   <= 1'b0;
         r1_inf   <= 1'b0;
         r1_zero  <= 1'b0;
         r1_inv   <= 1'b0;
         r1_pl    <= '0;
         r1_ph    <= '0;
      end else begin
         r1_valid <= flush ? 1'b0 : (w_s1_adv ? i_valid : r1_valid);
         if (w_acc) begin
            r1_tag  <= i_tag;
            r1_sign <= a_sign ^ b_sign;
            r1_exp  <= {a_exp[EXP_W], a_exp} + {b_exp[EXP_W], b_exp};
            r1_nan  <= w_nan;
            r1_inf  <= !w_nan && (a_is_inf || b_is_inf);
            r1_zero <= !w_nan && (a_is_zero || b_is_zero);
            r1_inv  <= w_inv && ven;
            r1_pl   <= {{L{1'b0}}, w_ma} * {{M{1'b0}}, w_mb[L-1:0]};
            r1_ph   <= {{H{1'b0}}, w_ma} * {{M{1'b0}}, w_mb[M-1:L]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r2_valid <= 1'b0;
         r2_tag   <= '0;
         r2_sign  <= 1'b0;
         r2_exp   <= '0;
         r2_nan   <= 1'b0;
         r2_inf   <= 1'b0;
         r2_zero  <= 1'b0;
         r2_inv   <= 1'b0;
         r2_frac  <= '0;
      end else begin
         r2_valid <= flush ? 1'b0 : (w_s2_adv ? r1_valid : r2_valid);
         if (w_s2_adv) begin
            r2_tag  <= r1_tag;
            r2_sign <= r1_sign;
            r2_exp  <= r1_exp + {{(EW-1){1'b0}}, w_p[PW-1]};
            r2_frac <= w_p[PW-1] ? w_p[PW-2:0] : {w_p[PW-3:0], 1'b0};
            r2_nan  <= r1_nan;
            r2_inf  <= r1_inf;
            r2_zero <= r1_zero;
            r2_inv  <= r1_inv;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid   <= 1'b0;
         o_tag     <= '0;
         o_sign    <= 1'b0;
         o_exp     <= '0;
         o_frac    <= '0;
         o_is_zero <= 1'b0;
         o_is_inf  <= 1'b0;
         o_is_nan  <= 1'b0;
         invalid   <= 1'b0;
      end else begin
         o_valid <= flush ? 1'b0 : (w_s3_adv ? r2_valid : o_valid);
         if (w_s3_adv) begin
            o_tag     <= r2_tag;
            o_sign    <= r2_sign;
            o_exp     <= r2_exp;
            o_frac    <= r2_frac;
            o_is_zero <= r2_zero;
            o_is_inf  <= r2_inf;
            o_is_nan  <= r2_nan;
            invalid   <= r2_inv;
         end
      end
   end
endmodule

// File: tb/tb_fpu_fmul_pipe.sv
// tb_fpu_fmul_pipe: table vectors plus queue scoreboard for the pipelined multiplier,
// with hand sequences for latency, backpressure, bubbles, flush and async reset (single and double).
`timescale 1ns/1ps
module tb_fpu_fmul_pipe;
   typedef struct packed {
      logic sa; logic [8:0] ea; logic [22:0] fa; logic [2:0] fla;
      logic sb; logic [8:0] eb; logic [22:0] fb; logic [2:0] flb;
      logic ven; logic [4:0] tag;
   } op_t;
   typedef struct packed {
      logic sign; logic [9:0] exp; logic [46:0] frac; logic [3:0] cls; logic [4:0] tag;
   } res_t;
   typedef struct packed { op_t op; res_t ex; } vec_t;

   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ven = 1'b0, i_valid = 1'b0, o_ready = 1'b1;
   logic i_ready, o_valid, o_sign, o_is_zero, o_is_inf, o_is_nan, invalid;
   logic [4:0] i_tag, o_tag;
   logic a_sign, b_sign, a_is_zero, a_is_inf, a_is_nan, b_is_zero, b_is_inf, b_is_nan;
   logic [8:0] a_exp, b_exp;
   logic [22:0] a_frac, b_frac;
   logic [9:0] o_exp;
   logic [46:0] o_frac;

   logic d_valid = 1'b0, d_i_ready, d_o_valid, d_o_sign, d_o_zero, d_o_inf, d_o_nan, d_inv;
   logic [4:0] d_o_tag;
   logic [11:0] d_exp = 12'd0;
   logic [51:0] d_frac = 52'h8_0000_0000_0000;
   logic [12:0] d_o_exp;
   logic [104:0] d_o_frac;

   int errs = 0, checks = 0;
   res_t sb[$];
   res_t cur_exp;
   logic acc_flag = 1'b0;
   vec_t tbl [13];

   fpu_fmul_pipe dut (
      .clk(clk), .rst(rst), .flush(flush), .ven(ven), .i_valid(i_valid), .i_ready(i_ready), .i_tag(i_tag),
      .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp), .a_frac(a_frac), .b_frac(b_frac),
      .a_is_zero(a_is_zero), .a_is_inf(a_is_inf), .a_is_nan(a_is_nan),
      .b_is_zero(b_is_zero), .b_is_inf(b_is_inf), .b_is_nan(b_is_nan),
      .o_valid(o_valid), .o_ready(o_ready), .o_tag(o_tag), .o_sign(o_sign), .o_exp(o_exp), .o_frac(o_frac),
      .o_is_zero(o_is_zero), .o_is_inf(o_is_inf), .o_is_nan(o_is_nan), .invalid(invalid));

   fpu_fmul_pipe #(.EXP_W(11), .FRAC_W(52), .TAG_W(5)) dut_d (
      .clk(clk), .rst(rst), .flush(1'b0), .ven(1'b1), .i_valid(d_valid), .i_ready(d_i_ready), .i_tag(5'd3),
      .a_sign(1'b0), .b_sign(1'b0), .a_exp(d_exp), .b_exp(d_exp), .a_frac(d_frac), .b_frac(d_frac),
      .a_is_zero(1'b0), .a_is_inf(1'b0), .a_is_nan(1'b0), .b_is_zero(1'b0), .b_is_inf(1'b0), .b_is_nan(1'b0),
      .o_valid(d_o_valid), .o_ready(1'b1), .o_tag(d_o_tag), .o_sign(d_o_sign), .o_exp(d_o_exp), .o_frac(d_o_frac),
      .o_is_zero(d_o_zero), .o_is_inf(d_o_inf), .o_is_nan(d_o_nan), .invalid(d_inv));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", n, act, req);
      end
   endtask

   function automatic res_t model(input op_t o);
      res_t r;
      logic [47:0] ma, mb, p;
      logic inv, n;
      ma = {24'd0, 1'b1, o.fa};
      mb = {24'd0, 1'b1, o.fb};
      p = ma * mb;
      inv = (o.fla[0] && o.fa[22]) || (o.flb[0] && o.fb[22]) || ((o.fla[1] || o.flb[1]) && (o.fla[2] || o.flb[2]));
      n = o.fla[0] || o.flb[0] || inv;
      r.sign = o.sa ^ o.sb;
      r.exp = 10'($signed(o.ea)) + 10'($signed(o.eb)) + 10'(p[47]);
      r.frac = p[47] ? p[46:0] : {p[45:0], 1'b0};
      r.cls = {!n && (o.fla[2] || o.flb[2]), !n && (o.fla[1] || o.flb[1]), n, inv && o.ven};
      r.tag = o.tag;
      return r;
   endfunction

   function automatic op_t rnd_op(input logic [4:0] tag);
      op_t o;
      o.sa = 1'($urandom);
      o.sb = 1'($urandom);
      o.ea = 9'($urandom_range(0, 60)) - 9'd30;
      o.eb = 9'($urandom_range(0, 60)) - 9'd30;
      o.fa = 23'($urandom);
      o.fb = 23'($urandom);
      o.fla = ($urandom_range(0, 5) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      o.flb = ($urandom_range(0, 5) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
      o.ven = 1'($urandom);
      o.tag = tag;
      return o;
   endfunction

   task automatic drive(input op_t o);
      a_sign = o.sa; a_exp = o.ea; a_frac = o.fa; {a_is_zero, a_is_inf, a_is_nan} = o.fla;
      b_sign = o.sb; b_exp = o.eb; b_frac = o.fb; {b_is_zero, b_is_inf, b_is_nan} = o.flb;
      ven = o.ven; i_tag = o.tag;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input op_t o, input res_t e, input bit rnd, output int w);
      drive(o);
      cur_exp = e;
      i_valid = 1'b1;
      w = 0;
      do begin
         @(posedge clk);
         w++;
         if (!acc_flag && rnd) begin
            #1 o_ready = ($urandom_range(0, 3) != 0);
         end
      end while (!acc_flag && w < 50);
      if (!acc_flag) chk("send_timeout", 128'(w), 128'(0));
      #1 i_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while ((sb.size() != 0 || o_valid) && k < 200) begin
         @(posedge clk);
         k++;
      end
      if (k == 200) chk("drain_timeout", 128'(sb.size()), 128'(0));
      #1;
   endtask

   // Decide at the falling edge what the next rising edge will transfer.
   always @(negedge clk) begin
      res_t e;
      acc_flag = 1'b0;
      if (!rst) begin
         if (o_valid && o_ready && !flush) begin
            if (sb.size() == 0) chk("unexpected_out", 128'(o_valid), 128'(0));
            else begin
               e = sb.pop_front();
               chk($sformatf("out_ctl tag%0d", e.tag), 128'({o_tag, o_sign, o_exp, o_is_zero, o_is_inf, o_is_nan, invalid}),
                   128'({e.tag, e.sign, e.exp, e.cls}));
               chk($sformatf("out_frac tag%0d", e.tag), 128'(o_frac), 128'(e.frac));
            end
         end
         if (flush) sb.delete();
         else if (i_valid && i_ready) begin
            sb.push_back(cur_exp);
            acc_flag = 1'b1;
         end
      end
   end

   always @(posedge rst) sb.delete();

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      op_t o;
      tbl[0]  = '{'{1'b0,9'h000,23'h400000,3'b000,1'b0,9'h000,23'h400000,3'b000,1'b1,5'd3},  '{1'b0,10'h001,47'h1000_0000_0000,4'b0000,5'd3}};
      tbl[1]  = '{'{1'b0,9'h000,23'h400000,3'b000,1'b0,9'h001,23'h000000,3'b000,1'b1,5'd4},  '{1'b0,10'h001,47'h4000_0000_0000,4'b0000,5'd4}};
      tbl[2]  = '{'{1'b1,9'h000,23'h400000,3'b000,1'b0,9'h001,23'h000000,3'b000,1'b1,5'd5},  '{1'b1,10'h001,47'h4000_0000_0000,4'b0000,5'd5}};
      tbl[3]  = '{'{1'b0,9'h000,23'h000000,3'b010,1'b0,9'h000,23'h000000,3'b100,1'b1,5'd6},  '{1'b0,10'h000,47'h0,4'b0011,5'd6}};
      tbl[4]  = '{'{1'b0,9'h000,23'h000000,3'b010,1'b0,9'h000,23'h000000,3'b100,1'b0,5'd7},  '{1'b0,10'h000,47'h0,4'b0010,5'd7}};
      tbl[5]  = '{'{1'b0,9'h000,23'h400000,3'b001,1'b0,9'h000,23'h000000,3'b000,1'b1,5'd8},  '{1'b0,10'h000,47'h4000_0000_0000,4'b0011,5'd8}};
      tbl[6]  = '{'{1'b0,9'h000,23'h200000,3'b001,1'b0,9'h000,23'h000000,3'b000,1'b1,5'd9},  '{1'b0,10'h000,47'h2000_0000_0000,4'b0010,5'd9}};
      tbl[7]  = '{'{1'b1,9'h000,23'h000000,3'b100,1'b0,9'h000,23'h000000,3'b000,1'b1,5'd10}, '{1'b1,10'h000,47'h0,4'b1000,5'd10}};
      tbl[8]  = '{'{1'b0,9'h000,23'h000000,3'b010,1'b0,9'h001,23'h000000,3'b000,1'b1,5'd11}, '{1'b0,10'h001,47'h0,4'b0100,5'd11}};
      tbl[9]  = '{'{1'b0,9'h1FD,23'h7FFFFF,3'b000,1'b0,9'h1FB,23'h7FFFFF,3'b000,1'b1,5'd12}, '{1'b0,10'h3F9,47'h7FFF_FE00_0001,4'b0000,5'd12}};
      tbl[10] = '{'{1'b1,9'h000,23'h000000,3'b010,1'b1,9'h000,23'h000000,3'b010,1'b1,5'd13}, '{1'b0,10'h000,47'h0,4'b0100,5'd13}};
      tbl[11] = '{'{1'b0,9'h000,23'h000000,3'b000,1'b0,9'h000,23'h400001,3'b001,1'b0,5'd14}, '{1'b0,10'h000,47'h4000_0100_0000,4'b0010,5'd14}};
      tbl[12] = '{'{1'b0,9'h07F,23'h000000,3'b000,1'b0,9'h07F,23'h000000,3'b000,1'b1,5'd15}, '{1'b0,10'h0FE,47'h0,4'b0000,5'd15}};
      drive('0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_o_valid", 128'(o_valid), 128'(0));
      chk("rst_i_ready", 128'(i_ready), 128'(1));
      chk("rst_fields", 128'({o_tag, o_sign, o_exp, o_is_zero, o_is_inf, o_is_nan, invalid}), 128'(0));
      chk("rst_frac", 128'(o_frac), 128'(0));

      // Double-precision 1.5*1.5 through the wide instance.
      chk("dbl_i_ready", 128'(d_i_ready), 128'(1));
      d_valid = 1'b1;
      step();
      d_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("dbl_valid", 128'(d_o_valid), 128'(1));
      chk("dbl_exp_tag", 128'({d_o_exp, d_o_tag, d_o_nan, d_inv}), 128'({13'd1, 5'd3, 1'b0, 1'b0}));
      chk("dbl_frac", 128'(d_o_frac), 128'd1 << 102);
      step();

      for (int i = 0; i < 13; i++) begin
         send(tbl[i].op, tbl[i].ex, 1'b0, w);
         chk($sformatf("tbl_accept_cycles %0d", i), 128'(w), 128'(1));
      end
      drain();

      // Latency: operands latched at one edge appear after the third edge.
      send(tbl[0].op, tbl[0].ex, 1'b0, w);
      @(negedge clk) chk("lat_e1", 128'(o_valid), 128'(0));
      @(negedge clk) chk("lat_e2", 128'(o_valid), 128'(0));
      @(negedge clk) chk("lat_e3", 128'(o_valid), 128'(1));
      step();
      drain();

      o_ready = 1'b0;
      fork
         for (int t = 1; t <= 6; t++) begin
            op_t q;
            int ww;
            q = rnd_op(5'(t));
            send(q, model(q), 1'b0, ww);
         end
         begin
            repeat (3) step();
            chk("bp_i_ready", 128'(i_ready), 128'(0));
            chk("bp_accepted", 128'(sb.size()), 128'(3));
            repeat (3) step();
            chk("bp_hold_tag", 128'(o_tag), 128'(1));
            o_ready = 1'b1;
         end
      join
      drain();

      // Bubble collapse behind a stalled output.
      o_ready = 1'b0;
      o = rnd_op(5'd16);
      send(o, model(o), 1'b0, w);
      repeat (2) step();
      chk("bub_stall_valid", 128'(o_valid), 128'(1));
      chk("bub_empty", 128'(i_ready), 128'(1));
      o = rnd_op(5'd17);
      send(o, model(o), 1'b0, w);
      chk("bub_s2_hole", 128'(i_ready), 128'(1));
      o = rnd_op(5'd18);
      send(o, model(o), 1'b0, w);
      chk("bub_full", 128'(i_ready), 128'(0));
      o_ready = 1'b1;
      drain();

      // Flush with three stalled ops in flight and a new op offered.
      o_ready = 1'b0;
      for (int t = 0; t < 3; t++) begin
         o = rnd_op(5'(20 + t));
         send(o, model(o), 1'b0, w);
      end
      chk("fl_full_valid", 128'(o_valid), 128'(1));
      o = rnd_op(5'd23);
      drive(o);
      cur_exp = model(o);
      i_valid = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      i_valid = 1'b0;
      o_ready = 1'b1;
      repeat (4) @(negedge clk) chk("fl_quiet", 128'(o_valid), 128'(0));
      chk("fl_sb_empty", 128'(sb.size()), 128'(0));
      step();

      // Flush overrides an accept on an empty, ready pipe.
      o = rnd_op(5'd24);
      drive(o);
      cur_exp = model(o);
      i_valid = 1'b1;
      flush = 1'b1;
      chk("fl2_i_ready", 128'(i_ready), 128'(1));
      step();
      flush = 1'b0;
      i_valid = 1'b0;
      repeat (4) @(negedge clk) chk("fl2_quiet", 128'(o_valid), 128'(0));
      step();

      for (int t = 0; t < 40; t++) begin
         o = rnd_op(5'(t));
         send(o, model(o), 1'b1, w);
      end
      o_ready = 1'b1;
      drain();

      // Asynchronous reset mid-stream on both instances.
      o_ready = 1'b0;
      d_valid = 1'b1;
      for (int t = 0; t < 3; t++) begin
         o = rnd_op(5'(25 + t));
         send(o, model(o), 1'b0, w);
      end
      chk("ar_pre_valid", 128'({o_valid, d_o_valid}), 128'(2'b11));
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", 128'({o_valid, d_o_valid}), 128'(0));
      chk("ar_ready", 128'({i_ready, d_i_ready}), 128'(2'b11));
      chk("ar_fields", 128'({o_tag, o_exp, o_frac}), 128'(0));
      d_valid = 1'b0;
      o_ready = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("ar_after_valid", 128'({o_valid, d_o_valid}), 128'(0));
      send(tbl[1].op, tbl[1].ex, 1'b0, w);
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
